// File: rtl/ram_access_ctrl_pkg.sv
// Shared types and encodings for the RAM access sequencer.
package ram_access_ctrl_pkg;

    localparam int RAM_AW = 4;
    localparam int RAM_DW = 4;

    // ram_16x4_sync pin encodings
    localparam logic CS_ACTIVE = 1'b0;
    localparam logic CS_IDLE   = 1'b1;
    localparam logic RW_READ   = 1'b1;
    localparam logic RW_WRITE  = 1'b0;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_CAP,
        ST_RESP
    } state_e;

endpackage

// File: rtl/ram_access_ctrl_if.sv
// Request/response handshake bundle between the core and the RAM sequencer.
interface ram_access_ctrl_if #(
    parameter int AW = 4,
    parameter int DW = 4
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;

    // Core side: issues requests, consumes responses.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    // Controller side.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ram_access_ctrl.sv
// Sequencer in front of ram_16x4_sync: clears the RAM after reset, then turns
// single read/write requests into one-cycle chip-select accesses.
//
// state | meaning
// INIT  | clear sweep, one address per cycle, csn low
// IDLE  | req_ready high, waiting for a request
// WR    | write access on the RAM pins (csn low, rwn low)
// RD    | read access on the RAM pins (csn low, rwn high)
// CAP   | RAM dataout valid, captured into rsp_rdata at the end of the cycle
// RESP  | rsp_valid high until the consumer takes it
//
// All RAM pin values are loaded on the edge that enters a state, so the pins
// show the access during the cycle the FSM spends in WR/RD.
module ram_access_ctrl
    import ram_access_ctrl_pkg::*;
#(
    parameter int            AW         = RAM_AW,
    parameter int            DW         = RAM_DW,
    parameter bit            INIT_EN    = 1'b1,
    parameter logic [DW-1:0] INIT_VALUE = '0
) (
    input  logic                clk,
    input  logic                reset,
    ram_access_ctrl_if.slave    bus,
    output logic                init_busy_o,
    output logic [AW-1:0]       ram_addr_o,
    output logic [DW-1:0]       ram_datain_o,
    output logic                ram_csn_o,
    output logic                ram_rwn_o,
    input  logic [DW-1:0]       ram_dataout_i
);

    localparam logic [AW-1:0] LAST_ADDR = '1;

    state_e        state_q;
    logic [AW-1:0] init_cnt_q;
    logic          init_busy_q;
    logic          req_ready_q;
    logic          rsp_valid_q;
    logic [DW-1:0] rsp_rdata_q;
    logic [AW-1:0] ram_addr_q;
    logic [DW-1:0] ram_datain_q;
    logic          ram_csn_q;
    logic          ram_rwn_q;

    // FSM with registered outputs; ram_addr_q/ram_datain_q double as the
    // latched request so later req_* changes cannot disturb an access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= INIT_EN ? ST_INIT : ST_IDLE;
            init_cnt_q   <= '0;
            init_busy_q  <= INIT_EN;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            ram_addr_q   <= '0;
            ram_datain_q <= '0;
            ram_csn_q    <= CS_IDLE;
            ram_rwn_q    <= RW_READ;
        end else begin
            case (state_q)
                ST_INIT: begin
                    ram_csn_q    <= CS_ACTIVE;
                    ram_rwn_q    <= RW_WRITE;
                    ram_addr_q   <= init_cnt_q;
                    ram_datain_q <= INIT_VALUE;
                    init_cnt_q   <= init_cnt_q + AW'(1);
                    if (init_cnt_q == LAST_ADDR) begin
                        state_q     <= ST_IDLE;
                        init_busy_q <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    ram_csn_q <= CS_IDLE;
                    ram_rwn_q <= RW_READ;
                    if (req_ready_q && bus.req_valid) begin
                        req_ready_q  <= 1'b0;
                        ram_addr_q   <= bus.req_addr;
                        ram_datain_q <= bus.req_wdata;
                        ram_csn_q    <= CS_ACTIVE;
                        ram_rwn_q    <= bus.req_we ? RW_WRITE : RW_READ;
                        state_q      <= bus.req_we ? ST_WR : ST_RD;
                    end else begin
                        // First IDLE cycle after INIT/reset raises ready.
                        req_ready_q <= 1'b1;
                    end
                end
                ST_WR: begin
                    ram_csn_q   <= CS_IDLE;
                    ram_rwn_q   <= RW_READ;
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                ST_RD: begin
                    ram_csn_q <= CS_IDLE;
                    ram_rwn_q <= RW_READ;
                    state_q   <= ST_CAP;
                end
                ST_CAP: begin
                    rsp_rdata_q <= ram_dataout_i;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    ram_csn_q   <= CS_IDLE;
                    ram_rwn_q   <= RW_READ;
                    req_ready_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign init_busy_o   = init_busy_q;
    assign ram_addr_o    = ram_addr_q;
    assign ram_datain_o  = ram_datain_q;
    assign ram_csn_o     = ram_csn_q;
    assign ram_rwn_o     = ram_rwn_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl with a behavioural ram_16x4_sync stand-in.
module tb_ram_access_ctrl;

    localparam int       PERIOD   = 10;
    localparam logic [3:0] INIT_VAL = 4'h0;

    logic       clk = 1'b0;
    logic       reset;
    logic       init_busy;
    logic [3:0] ram_addr;
    logic [3:0] ram_datain;
    logic       ram_csn;
    logic       ram_rwn;
    logic [3:0] ram_dout;

    int n_vec  = 0;
    int n_fail = 0;

    ram_access_ctrl_if #(.AW(4), .DW(4)) bus ();

    ram_access_ctrl #(
        .AW(4), .DW(4), .INIT_EN(1'b1), .INIT_VALUE(INIT_VAL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .init_busy_o   (init_busy),
        .ram_addr_o    (ram_addr),
        .ram_datain_o  (ram_datain),
        .ram_csn_o     (ram_csn),
        .ram_rwn_o     (ram_rwn),
        .ram_dataout_i (ram_dout)
    );

    always #(PERIOD/2) clk = ~clk;

    // ram_16x4_sync behaviour: registered read, write on csn low & rwn low,
    // reset_n tied to ~reset.
    logic [3:0] ram_mem [16];
    wire        ram_reset_n = ~reset;
    always @(posedge clk or negedge ram_reset_n) begin
        if (!ram_reset_n) ram_dout <= 4'h0;
        else if (!ram_csn) begin
            if (!ram_rwn) ram_mem[ram_addr] <= ram_datain;
            else          ram_dout <= ram_mem[ram_addr];
        end
    end

    // Reference model: RAM contents as the core sees them, plus the
    // accesses and responses that must appear, in order.
    typedef struct { logic [3:0] a; logic [3:0] d; } wr_t;
    logic [3:0] model_mem [16];
    wr_t        exp_wr_q  [$];
    logic [3:0] exp_rd_q  [$];
    logic [3:0] exp_rsp_q [$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) model_mem[i] = INIT_VAL;
    endtask

    // Per-cycle comparison of RAM pins and response channel against the model.
    int   sweep_idx = 0;
    logic prev_low  = 1'b0;
    always @(negedge clk) begin
        wr_t        w;
        logic [3:0] r;
        if (reset) begin
            exp_wr_q.delete();
            exp_rd_q.delete();
            exp_rsp_q.delete();
            sweep_idx = 0;
            prev_low  = 1'b0;
        end else begin
            if (!ram_csn && !ram_rwn && sweep_idx < 16) begin
                check("sweep_addr", {4'h0, ram_addr}, 8'(sweep_idx));
                check("sweep_data", {4'h0, ram_datain}, {4'h0, INIT_VAL});
                sweep_idx++;
                prev_low = 1'b0;
            end else begin
                if (!ram_csn) begin
                    check("csn_one_cycle", {7'h0, prev_low}, 8'h0);
                    if (!ram_rwn) begin
                        if (exp_wr_q.size() == 0) check("unexpected_write", 8'h1, 8'h0);
                        else begin
                            w = exp_wr_q.pop_front();
                            check("wr_addr", {4'h0, ram_addr}, {4'h0, w.a});
                            check("wr_data", {4'h0, ram_datain}, {4'h0, w.d});
                        end
                    end else begin
                        if (exp_rd_q.size() == 0) check("unexpected_read", 8'h1, 8'h0);
                        else begin
                            r = exp_rd_q.pop_front();
                            check("rd_addr", {4'h0, ram_addr}, {4'h0, r});
                        end
                    end
                end
                prev_low = !ram_csn;
            end
            if (bus.rsp_valid) begin
                if (exp_rsp_q.size() == 0) check("unexpected_rsp", 8'h1, 8'h0);
                else begin
                    check("rsp_rdata", {4'h0, bus.rsp_rdata}, {4'h0, exp_rsp_q[0]});
                    if (bus.rsp_ready) void'(exp_rsp_q.pop_front());
                end
            end
        end
    end

    // Call at posedge+1. Presents a request, waits for req_ready, and returns
    // at posedge+1 just after the accept edge (with req_valid dropped).
    task automatic send(input bit we, input logic [3:0] a, input logic [3:0] d, output time t_acc);
        int n = 0;
        wr_t w;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        while (!bus.req_ready && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.req_ready) check("req_ready_timeout", 8'h1, 8'h0);
        if (we) begin
            w.a = a; w.d = d;
            exp_wr_q.push_back(w);
            model_mem[a] = d;
        end else begin
            exp_rd_q.push_back(a);
            exp_rsp_q.push_back(model_mem[a]);
        end
        @(posedge clk);
        t_acc = $time;
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Waits for a response with rsp_ready high; returns at posedge+1 after handshake.
    task automatic wait_rsp(output logic [3:0] d);
        int n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.rsp_valid) check("rsp_timeout", 8'h1, 8'h0);
        d = bus.rsp_rdata;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        time        t, tp;
        logic [3:0] d;

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 4'h0;
        bus.req_wdata = 4'h0;
        bus.rsp_ready = 1'b1;
        model_clear();

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_req_ready", {7'h0, bus.req_ready}, 8'h0);
        check("rst_rsp_valid", {7'h0, bus.rsp_valid}, 8'h0);
        check("rst_rsp_rdata", {4'h0, bus.rsp_rdata}, 8'h0);
        check("rst_csn",       {7'h0, ram_csn}, 8'h1);
        check("rst_rwn",       {7'h0, ram_rwn}, 8'h1);
        check("rst_addr",      {4'h0, ram_addr}, 8'h0);
        check("rst_datain",    {4'h0, ram_datain}, 8'h0);
        check("rst_init_busy", {7'h0, init_busy}, 8'h1);

        // Clear sweep: init_busy high for 16 cycles, addresses 0..15
        #1 reset = 1'b0;
        check("init_busy_pre", {7'h0, init_busy}, 8'h1);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            check("init_csn",  {7'h0, ram_csn}, 8'h0);
            check("init_rwn",  {7'h0, ram_rwn}, 8'h0);
            check("init_addr", {4'h0, ram_addr}, 8'(k - 1));
            check("init_busy", {7'h0, init_busy}, (k < 16) ? 8'h1 : 8'h0);
            check("init_req_ready", {7'h0, bus.req_ready}, 8'h0);
        end
        @(posedge clk); #1;
        check("post_init_ready", {7'h0, bus.req_ready}, 8'h1);
        check("post_init_csn",   {7'h0, ram_csn}, 8'h1);

        // Cleared word reads back as INIT_VALUE
        send(1'b0, 4'h9, 4'h0, t);
        wait_rsp(d);
        check("rd9_after_init", {4'h0, d}, 8'h00);

        // Write 5 to 4, then read it: csn low one cycle, rsp in third cycle
        send(1'b1, 4'h4, 4'h5, t);
        check("wr_csn_low",  {7'h0, ram_csn}, 8'h0);
        check("wr_rwn",      {7'h0, ram_rwn}, 8'h0);
        @(posedge clk); #1;
        check("wr_csn_high", {7'h0, ram_csn}, 8'h1);
        check("wr_ready",    {7'h0, bus.req_ready}, 8'h1);
        send(1'b0, 4'h4, 4'h0, t);
        check("rd_csn_low",  {7'h0, ram_csn}, 8'h0);
        check("rd_rwn",      {7'h0, ram_rwn}, 8'h1);
        check("lat_c1",      {7'h0, bus.rsp_valid}, 8'h0);
        @(posedge clk); #1;
        check("rd_csn_high", {7'h0, ram_csn}, 8'h1);
        check("lat_c2",      {7'h0, bus.rsp_valid}, 8'h0);
        @(posedge clk); #1;
        check("lat_c3",      {7'h0, bus.rsp_valid}, 8'h1);
        check("rd4_data",    {4'h0, bus.rsp_rdata}, 8'h05);
        @(posedge clk); #1;
        check("rd4_done",    {7'h0, bus.rsp_valid}, 8'h0);
        check("rd4_ready",   {7'h0, bus.req_ready}, 8'h1);

        // Response stall: read F with rsp_ready low for 5 cycles
        send(1'b1, 4'hF, 4'h7, t);
        bus.rsp_ready = 1'b0;
        send(1'b0, 4'hF, 4'h0, t);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("stall_valid", {7'h0, bus.rsp_valid}, 8'h1);
            check("stall_data",  {4'h0, bus.rsp_rdata}, 8'h07);
            check("stall_ready", {7'h0, bus.req_ready}, 8'h0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_release_valid", {7'h0, bus.rsp_valid}, 8'h0);
        check("stall_release_ready", {7'h0, bus.req_ready}, 8'h1);

        // Back-to-back writes data=addr, req_valid held high: accept every 2 cycles
        tp = 0;
        for (int i = 0; i < 16; i++) begin
            send(1'b1, 4'(i), 4'(i), t);
            if (i > 0) check("wr_spacing", 8'((t - tp) / PERIOD), 8'h2);
            tp = t;
        end
        for (int i = 0; i < 16; i++) begin
            send(1'b0, 4'(i), 4'h0, t);
            wait_rsp(d);
            check("rd_all", {4'h0, d}, 8'(i));
        end

        // Request fields changed after accept must not affect the write
        send(1'b1, 4'h2, 4'hC, t);
        bus.req_addr  = 4'h5;
        bus.req_wdata = 4'h3;
        @(posedge clk); #1;
        send(1'b0, 4'h2, 4'h0, t);
        wait_rsp(d);
        check("latched_wr", {4'h0, d}, 8'h0C);
        send(1'b0, 4'h5, 4'h0, t);
        wait_rsp(d);
        check("untouched_5", {4'h0, d}, 8'h05);

        // Reset during the WR cycle of write A to 3
        send(1'b1, 4'h3, 4'hA, t);
        check("pre_rst_csn", {7'h0, ram_csn}, 8'h0);
        reset = 1'b1;
        #1;
        check("async_csn", {7'h0, ram_csn}, 8'h1);
        check("rst_no_rsp", {7'h0, bus.rsp_valid}, 8'h0);
        model_clear();
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check("reinit_addr0", {4'h0, ram_addr}, 8'h0);
        check("reinit_csn",   {7'h0, ram_csn}, 8'h0);
        check("reinit_busy",  {7'h0, init_busy}, 8'h1);
        send(1'b0, 4'h3, 4'h0, t);
        wait_rsp(d);
        check("rd3_after_rst", {4'h0, d}, {4'h0, INIT_VAL});
        repeat (3) @(posedge clk);
        check("queues_drained", 8'(exp_wr_q.size() + exp_rd_q.size() + exp_rsp_q.size()), 8'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
